// File: rtl/jtframe_db9_multi.sv
// Multi-port DB9 joystick reader: drives the shared select line through an 8-phase
// sequence, classifies each pad as Atari / Sega 3-button / Sega 6-button, publishes per frame.
module jtframe_db9_multi #(
  parameter int PORTS     = 2,
  parameter int PHASE_CYC = 480,
  parameter int IDLE_CYC  = 96000
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [6*PORTS-1:0]   db9_in,
  output logic                 joy_sel,
  output logic [12*PORTS-1:0]  joy_out,
  output logic [2*PORTS-1:0]   joy_type,
  output logic                 frame_done
);

  localparam int MAXC = (PHASE_CYC > IDLE_CYC) ? PHASE_CYC : IDLE_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] PH_LAST   = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

  localparam logic [3:0] ST_PH0  = 4'd0;
  localparam logic [3:0] ST_PH1  = 4'd1;
  localparam logic [3:0] ST_PH5  = 4'd5;
  localparam logic [3:0] ST_PH6  = 4'd6;
  localparam logic [3:0] ST_IDLE = 4'd8;

  logic [3:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_sel;
  logic                r_frame_done;
  logic [6*PORTS-1:0]  r_meta;
  logic [6*PORTS-1:0]  r_sync;
  logic [12*PORTS-1:0] r_joy_out;
  logic [2*PORTS-1:0]  r_joy_type;

  logic                w_ph_end;
  logic                w_idle_end;
  logic                w_adv;
  logic [3:0]          w_state_nxt;
  logic [12*PORTS-1:0] w_pub_out;
  logic [2*PORTS-1:0]  w_pub_type;

  assign w_ph_end    = (r_state != ST_IDLE) && (r_cnt == PH_LAST);
  assign w_idle_end  = (r_state == ST_IDLE) && (r_cnt == IDLE_LAST);
  assign w_adv       = w_ph_end | w_idle_end;
  assign w_state_nxt = w_idle_end ? ST_PH0 : (r_state + 4'd1);

  // Sequencer: PH0..PH7 then IDLE; select is high in even phases and in IDLE.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PH0;
      r_cnt        <= '0;
      r_sel        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_idle_end;
      if (w_adv) begin
        r_state <= w_state_nxt;
        r_cnt   <= '0;
        r_sel   <= (w_state_nxt == ST_IDLE) || !w_state_nxt[0];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Pins are inverted on entry so the synchroniser reset value means "released".
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= ~db9_in;
      r_sync <= r_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [5:0] w_pin;
      logic [3:0] r_dir;
      logic       r_p6_hi;
      logic       r_p9_hi;
      logic       r_p6_lo;
      logic       r_p9_lo;
      logic [3:0] r_zyxm;
      logic       r_sega;
      logic       r_six;

      assign w_pin = r_sync[6*gi +: 6];

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          r_dir   <= '0;
          r_p6_hi <= 1'b0;
          r_p9_hi <= 1'b0;
          r_p6_lo <= 1'b0;
          r_p9_lo <= 1'b0;
          r_zyxm  <= '0;
          r_sega  <= 1'b0;
          r_six   <= 1'b0;
        end else if (w_idle_end) begin
          r_sega <= 1'b0;
          r_six  <= 1'b0;
        end else if (w_ph_end) begin
          case (r_state)
            ST_PH0: begin
              r_dir   <= w_pin[3:0];
              r_p6_hi <= w_pin[4];
              r_p9_hi <= w_pin[5];
            end
            ST_PH1: begin
              // A Sega pad grounds left and right while select is low.
              if (w_pin[2] && w_pin[3]) r_sega <= 1'b1;
              r_p6_lo <= w_pin[4];
              r_p9_lo <= w_pin[5];
            end
            ST_PH5: begin
              if ((&w_pin[3:0]) && r_sega) r_six <= 1'b1;
            end
            ST_PH6: begin
              if (r_six) r_zyxm <= w_pin[3:0];
            end
            default: ;
          endcase
        end
      end

      // Bit order {mode,x,y,z,start,c,b,a,right,left,down,up}; r_zyxm is {mode,x,y,z}.
      assign w_pub_out[12*gi +: 12] = r_sega ?
          {(r_six ? r_zyxm : 4'b0000), r_p9_lo, r_p9_hi, r_p6_hi, r_p6_lo, r_dir} :
          {4'b0000, 1'b0, 1'b0, r_p9_hi, r_p6_hi, r_dir};
      assign w_pub_type[2*gi +: 2] = r_sega ? (r_six ? 2'd2 : 2'd1) : 2'd0;
    end
  endgenerate

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_joy_out  <= '0;
      r_joy_type <= '0;
    end else if (w_idle_end) begin
      r_joy_out  <= w_pub_out;
      r_joy_type <= w_pub_type;
    end
  end

  assign joy_sel    = r_sel;
  assign joy_out    = r_joy_out;
  assign joy_type   = r_joy_type;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_jtframe_db9_multi.sv
// Bench for jtframe_db9_multi: behavioural pad models on four ports, expected frames
// queued at stimulus time and checked by an independent monitor on each frame_done.
module tb_jtframe_db9_multi;
  localparam int PORTS = 4;
  localparam int PC    = 8;
  localparam int IC    = 24;
  localparam int FRAME = 8*PC + IC;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_ATARI = 2'd1;
  localparam logic [1:0] K_SEGA3 = 2'd2;
  localparam logic [1:0] K_SEGA6 = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] btn;   // {mode,x,y,z,start,c,b,a,right,left,down,up}, active-high
  } pad_t;

  typedef struct packed {
    logic [12*PORTS-1:0] out;
    logic [2*PORTS-1:0]  typ;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [6*PORTS-1:0]  db9_in;
  logic                joy_sel;
  logic [12*PORTS-1:0] joy_out;
  logic [2*PORTS-1:0]  joy_type;
  logic                frame_done;

  pad_t pads [PORTS];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   fall_cnt = 0;
  int   hi_cnt = 0;
  logic sel_d = 1'b1;
  int   cyc_since = 0;

  always #5 clk = ~clk;

  jtframe_db9_multi #(.PORTS(PORTS), .PHASE_CYC(PC), .IDLE_CYC(IC)) dut (
    .clk_sys    (clk),
    .rst_n      (rst_n),
    .db9_in     (db9_in),
    .joy_sel    (joy_sel),
    .joy_out    (joy_out),
    .joy_type   (joy_type),
    .frame_done (frame_done)
  );

  // Pad-side view of the select line: count low pulses, restart after a long high.
  always @(posedge clk) begin
    sel_d <= joy_sel;
    if (joy_sel) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= 12) fall_cnt <= 0;
    end else begin
      hi_cnt <= 0;
      if (sel_d) fall_cnt <= fall_cnt + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_since <= 0;
    else        cyc_since <= frame_done ? 1 : cyc_since + 1;
  end

  function automatic logic [5:0] pad_pins(pad_t p, logic sel, int f);
    logic u, d, l, r, a, b, c, st, z, y, x, m;
    {m, x, y, z, st, c, b, a, r, l, d, u} = p.btn;
    case (p.kind)
      K_ATARI: return ~{b, a, r, l, d, u};
      K_SEGA3, K_SEGA6: begin
        if (sel) begin
          if (p.kind == K_SEGA6 && f == 3) return ~{c, b, m, x, y, z};
          return ~{c, b, r, l, d, u};
        end
        if (p.kind == K_SEGA6 && f == 3) return ~{st, a, 4'b1111};
        return ~{st, a, 2'b11, d, u};
      end
      default: return 6'h3F;
    endcase
  endfunction

  always_comb begin
    db9_in = '1;
    for (int i = 0; i < PORTS; i++) db9_in[6*i +: 6] = pad_pins(pads[i], joy_sel, fall_cnt);
  end

  function automatic logic [11:0] exp_btn(pad_t p);
    case (p.kind)
      K_ATARI: return {6'b0, p.btn[5:0]};
      K_SEGA3: return {4'b0, p.btn[7:0]};
      K_SEGA6: return p.btn;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [1:0] exp_type(pad_t p);
    case (p.kind)
      K_SEGA3: return 2'd1;
      K_SEGA6: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic pad_t rand_pad();
    pad_t p;
    p.kind = 2'($urandom_range(0, 3));
    p.btn  = 12'($urandom);
    // Combinations a real pad cannot tell apart from a different pad type.
    if (p.kind == K_ATARI && p.btn[2] && p.btn[3]) p.btn[3] = 1'b0;
    if (p.kind == K_SEGA3 && p.btn[0] && p.btn[1]) p.btn[1] = 1'b0;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < PORTS; i++) begin
      e.out[12*i +: 12] = exp_btn(pads[i]);
      e.typ[2*i +: 2]   = exp_type(pads[i]);
    end
    sb.push_back(e);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3*FRAME);
    chk("frame_timeout", 64'(frame_done), 64'd1);
  endtask

  // Monitor: compares each published frame against the queue, watches for glitches.
  initial begin
    logic [12*PORTS-1:0] last_out;
    logic prev_sel;
    int   nfall;
    int   nframe;
    exp_t e;
    last_out = '0;
    prev_sel = 1'b1;
    nfall    = 0;
    nframe   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out = joy_out;
        prev_sel = joy_sel;
        nfall    = 0;
      end else begin
        if (prev_sel && !joy_sel) nfall++;
        prev_sel = joy_sel;
        if (frame_done) begin
          nframe++;
          chk("frame_period", 64'(cyc_since), 64'(FRAME));
          chk("sel_pulses", 64'(nfall), 64'd4);
          nfall = 0;
          if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
          end else begin
            e = sb.pop_front();
            $display("frame %0d: joy_out=%h (exp %h) joy_type=%b (exp %b)",
                     nframe, joy_out, e.out, joy_type, e.typ);
            chk("joy_out", 64'(joy_out), 64'(e.out));
            chk("joy_type", 64'(joy_type), 64'(e.typ));
          end
        end else begin
          chk("no_glitch", 64'(joy_out), 64'(last_out));
        end
        last_out = joy_out;
      end
    end
  end

  initial begin
    for (int i = 0; i < PORTS; i++) pads[i] = '{kind: K_NONE, btn: 12'h000};
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sel", 64'(joy_sel), 64'd1);
    chk("rst_out", 64'(joy_out), 64'd0);
    chk("rst_type", 64'(joy_type), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);

    push_exp();
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_frame();

    pads[0] = '{kind: K_ATARI, btn: 12'h011};
    repeat (2) begin push_exp(); wait_frame(); end

    pads[1] = '{kind: K_SEGA3, btn: 12'h098};
    push_exp(); wait_frame();

    pads[0] = '{kind: K_SEGA6, btn: 12'hC40};
    push_exp(); wait_frame();
    pads[0] = '{kind: K_NONE, btn: 12'h000};
    pads[1] = '{kind: K_NONE, btn: 12'h000};
    push_exp(); wait_frame();

    pads[0] = '{kind: K_SEGA6, btn: 12'h100};
    push_exp(); wait_frame();
    push_exp();
    repeat (3*PC + 3) @(negedge clk);
    chk("sel_ph3", 64'(joy_sel), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'(joy_out), 64'd0);
    chk("midrst_type", 64'(joy_type), 64'd0);
    chk("midrst_sel", 64'(joy_sel), 64'd1);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_frame();

    pads[0] = '{kind: K_ATARI, btn: 12'h026};
    pads[1] = '{kind: K_SEGA3, btn: 12'h0C5};
    pads[2] = '{kind: K_SEGA6, btn: 12'h3F3};
    pads[3] = '{kind: K_NONE,  btn: 12'hFFF};
    repeat (2) begin push_exp(); wait_frame(); end
    chk("mixed_type", 64'(joy_type), 64'(8'b00_10_01_00));

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < PORTS; i++) pads[i] = rand_pad();
      push_exp();
      wait_frame();
    end

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
